// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 8N1, LSB first, idle high, mid-bit sampling.
// Define UART_RX_PARITY_EN to switch the frame to 8E1 with a PARITY state.
module uart_rx_deser #(
   parameter int CLK_DIV = 260,
   parameter int CNT_W   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       rx_busy,
   output logic       rx_end,
   output logic [7:0] rx_data,
   output logic       rx_err
);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(CLK_DIV - 1);

   state_t           state_reg, state_next;
   logic             rx_meta_reg, rx_s_reg;
   logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       rx_data_reg, rx_data_next;
   logic             rx_busy_reg, rx_busy_next;
   logic             rx_end_reg, rx_end_next;
   logic             rx_err_reg, rx_err_next;
`ifdef UART_RX_PARITY_EN
   logic             par_err_reg, par_err_next;
`endif

   // rx is asynchronous to clk; nothing downstream looks at it before rx_s_reg.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_s_reg    <= rx_meta_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         div_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         rx_data_reg <= '0;
         rx_busy_reg <= 1'b0;
         rx_end_reg  <= 1'b0;
         rx_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         div_cnt_reg <= div_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         rx_data_reg <= rx_data_next;
         rx_busy_reg <= rx_busy_next;
         rx_end_reg  <= rx_end_next;
         rx_err_reg  <= rx_err_next;
`ifdef UART_RX_PARITY_EN
         par_err_reg <= par_err_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg + CNT_W'(1);
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      rx_data_next = rx_data_reg;
      rx_end_next  = 1'b0;
      rx_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_next = par_err_reg;
`endif
      case (state_reg)
         IDLE: begin
            div_cnt_next = '0;
            if (!rx_s_reg) state_next = START;
         end
         START: begin
            // A start bit that is high again at its midpoint was a glitch.
            if (div_cnt_reg == HALF_M1) begin
               div_cnt_next = '0;
               bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
               par_err_next = 1'b0;
`endif
               state_next   = rx_s_reg ? IDLE : DATA;
            end
         end
         DATA: begin
            if (div_cnt_reg == DIV_M1) begin
               div_cnt_next = '0;
               shift_next   = {rx_s_reg, shift_reg[7:1]};
               if (bit_cnt_reg == 3'd7) begin
                  bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                  state_next   = PARITY;
`else
                  state_next   = STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (div_cnt_reg == DIV_M1) begin
               div_cnt_next = '0;
               par_err_next = (^shift_reg) ^ rx_s_reg;
               state_next   = STOP;
            end
         end
`endif
         STOP: begin
            // Returning to IDLE at mid stop bit lets the next start edge be caught.
            if (div_cnt_reg == DIV_M1) begin
               div_cnt_next = '0;
               state_next   = IDLE;
`ifdef UART_RX_PARITY_EN
               if (rx_s_reg && !par_err_reg) begin
`else
               if (rx_s_reg) begin
`endif
                  rx_end_next  = 1'b1;
                  rx_data_next = shift_reg;
               end else begin
                  rx_err_next  = 1'b1;
               end
            end
         end
         default: begin
            state_next   = IDLE;
            div_cnt_next = '0;
         end
      endcase
      rx_busy_next = (state_next != IDLE);
   end

   assign rx_busy = rx_busy_reg;
   assign rx_end  = rx_end_reg;
   assign rx_err  = rx_err_reg;
   assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser (CLK_DIV=16); covers UART_RX_PARITY_EN when defined.
module tb_uart_rx_deser;
   localparam int CLK_DIV = 16;
   localparam int HALF    = CLK_DIV / 2;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx_busy, rx_end, rx_err;
   logic [7:0] rx_data;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   logic prev_end = 1'b0;
   logic prev_err = 1'b0;

   uart_rx_deser #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .rx_busy (rx_busy),
      .rx_end  (rx_end),
      .rx_data (rx_data),
      .rx_err  (rx_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CLK_DIV) @(posedge clk);
      #1;
   endtask

   // One frame on the line; optionally queues the expected strobe first.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                             input logic push, input logic exp_err, input logic [7:0] exp_data);
      exp_t e;
      if (push) begin
         e.err  = exp_err;
         e.data = exp_data;
         sb.push_back(e);
      end
      $display("frame data=%02h stop=%0b par=%0b expect %s data=%02h", d, stop_bit, par_bit,
               !push ? "none" : (exp_err ? "err" : "end"), exp_data);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_bit);
`endif
      drive_bit(stop_bit);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && (rx_end || rx_err)) begin
         check("both_strobes", {31'd0, rx_end & rx_err}, 32'd0);
         if (rx_end) check("end_one_cycle", {31'd0, prev_end}, 32'd0);
         if (rx_err) check("err_one_cycle", {31'd0, prev_err}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_strobe", {30'd0, rx_err, rx_end}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("strobe_kind_is_err", {31'd0, rx_err}, {31'd0, e.err});
            check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            $display("strobe %s rx_data=%02h", rx_err ? "err" : "end", rx_data);
         end
      end
      prev_end <= rx_end;
      prev_err <= rx_err;
   end

   initial begin
      int busy_cycles;
      int waited;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("reset_busy", {31'd0, rx_busy}, 32'd0);
      check("reset_end",  {31'd0, rx_end},  32'd0);
      check("reset_err",  {31'd0, rx_err},  32'd0);
      check("reset_data", {24'd0, rx_data}, 32'd0);
      idle(4);

      // T1: 0x55, rx_busy rises 3 cycles after the falling edge.
      fork
         send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
         begin
            repeat (2) @(posedge clk);
            #2;
            check("t1_busy_at_2", {31'd0, rx_busy}, 32'd0);
            @(posedge clk);
            #2;
            check("t1_busy_at_3", {31'd0, rx_busy}, 32'd1);
         end
      join
      idle(2 * CLK_DIV);
      check("t1_busy_after", {31'd0, rx_busy}, 32'd0);

      // T2: 4-cycle glitch must be rejected at mid start bit.
      rx = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 24; i++) begin
         if (i == 4) rx = 1'b1;
         @(posedge clk);
         #1;
         if (rx_busy) busy_cycles++;
      end
      $display("glitch busy_cycles=%0d", busy_cycles);
      check("t2_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
      check("t2_busy_le_half", {31'd0, busy_cycles <= HALF}, 32'd1);
      check("t2_data_held", {24'd0, rx_data}, 32'h55);
      idle(CLK_DIV);

      // T3: bad stop bit; rx_data keeps 0x55.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
      idle(3 * CLK_DIV);
      check("t3_data_held", {24'd0, rx_data}, 32'h55);

      // T4: back-to-back frames, no idle gap.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
      idle(2 * CLK_DIV);
      check("t4_data", {24'd0, rx_data}, 32'h3C);

      // T5: reset during data bit 4 aborts the frame silently.
      fork
         send_frame(8'hF8, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
         begin
            repeat (84) @(posedge clk);
            #2;
            check("t5_busy_before_reset", {31'd0, rx_busy}, 32'd1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            #1;
            check("t5_busy", {31'd0, rx_busy}, 32'd0);
            check("t5_end",  {31'd0, rx_end},  32'd0);
            check("t5_err",  {31'd0, rx_err},  32'd0);
            check("t5_data", {24'd0, rx_data}, 32'd0);
         end
      join
      idle(2 * CLK_DIV);
      send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 8'h81);
      idle(2 * CLK_DIV);
      check("t5_data_after", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
      // T6: even parity; 0x07 has three ones so the parity bit must be 1.
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07);
      idle(2 * CLK_DIV);
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07);
      idle(2 * CLK_DIV);
      check("t6_data_held", {24'd0, rx_data}, 32'h07);
`endif

      waited = 0;
      while (sb.size() != 0 && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
